accelerator_read_keys: RTL and testbench
========================================

Name: accelerator_read_keys

Overview:
- Read-side counterpart of the write-key head in the DNC interface block.
- Accepts the R×W read-key matrix k_t^{r}[i,k] as an element stream from the controller: R read heads, W word width.
- Re-emits each element, registered, with row/element enable strobes for the content-addressing read path.
- Sequenced by a START/READY handshake, like its sibling head blocks.

Parameters:
DATA_SIZE  64  width of data words, size inputs and internal counters
CONTROL_SIZE  64  control-field width; kept for uniform instantiation, unused internally

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
START  input  1  begin one matrix transfer (sampled in STARTER only)
READY  output  1  one-cycle pulse, transfer complete
K_IN_I_ENABLE  input  1  marks first element of a row (new read head i)
K_IN_K_ENABLE  input  1  element valid on K_IN
K_OUT_I_ENABLE  output  1  one-cycle strobe, first element of row on K_OUT
K_OUT_K_ENABLE  output  1  one-cycle strobe, element valid on K_OUT
SIZE_R_IN  input  DATA_SIZE  number of read heads R (unsigned)
SIZE_W_IN  input  DATA_SIZE  word width W (unsigned)
K_IN  input  DATA_SIZE  key element in
K_OUT  output  DATA_SIZE  key element out (registered)

Behaviour:
- Reset (RST=0, asynchronous):
  - READY=0, K_OUT_I_ENABLE=0, K_OUT_K_ENABLE=0, K_OUT=0.
  - Counters index_i=0, index_k=0; latched sizes=0; state STARTER.
  - Applies immediately, including mid-transfer; no READY is generated for an aborted transfer.
- Strobes and data:
  - READY, K_OUT_I_ENABLE and K_OUT_K_ENABLE default to 0 every cycle unless set below.
  - K_OUT holds its last value between strobes.
- STARTER:
  - START=1: latch SIZE_R_IN and SIZE_W_IN, clear counters.
  - If either size is 0, go to ENDER (no elements transferred); otherwise go to INPUT_I.
- INPUT_I (waiting for first element of row index_i):
  - Accept only when K_IN_I_ENABLE=1 and K_IN_K_ENABLE=1.
  - Next cycle: K_OUT=K_IN, K_OUT_I_ENABLE=1, K_OUT_K_ENABLE=1.
  - K_IN_K_ENABLE=1 with K_IN_I_ENABLE=0: not accepted; wait.
- INPUT_K (waiting for element index_k, with index_k>0):
  - Accept when K_IN_K_ENABLE=1; K_IN_I_ENABLE is ignored.
  - Next cycle: K_OUT=K_IN, K_OUT_K_ENABLE=1, K_OUT_I_ENABLE=0.
- Counter update on each accept:
  - index_k < W-1: index_k++, go to INPUT_K.
  - index_k = W-1 and index_i < R-1: index_k=0, index_i++, go to INPUT_I.
  - index_k = W-1 and index_i = R-1: go to ENDER.
  - W=1: every element is row-first, so the block stays in INPUT_I between rows.
- ENDER: READY=1 for exactly one cycle, counters cleared, return to STARTER.
- Latency and throughput:
  - Accepted element to output strobe: 1 cycle.
  - One element per cycle maximum (back-to-back enables accepted every cycle).
  - Last element's output strobe and READY occur in consecutive cycles.
- START while not in STARTER: ignored. START held high: a new transfer begins the cycle after READY.
- Size inputs are sampled only at START; later changes have no effect. Comparisons are unsigned, full DATA_SIZE width; counters never wrap within a legal transfer.

Optional Feature:
- Macro: ACCELERATOR_READ_KEYS_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output port ERROR (1 bit), reset 0; cleared to 0 on an accepted START.
  - Set sticky to 1 on: K_IN_I_ENABLE=1 in INPUT_K; K_IN_K_ENABLE=1 with K_IN_I_ENABLE=0 in INPUT_I; K_IN_K_ENABLE=1 in STARTER.
  - Datapath behaviour is unchanged.
- Undefined: no ERROR port; those conditions are silently ignored as described above.

Test Plan:
- R=2, W=3, K_IN=1..6 with back-to-back enables (I strobe on elements 1 and 4) -> K_OUT=1..6 one cycle later; K_OUT_I_ENABLE on values 1 and 4; six K_OUT_K_ENABLE pulses; READY single pulse the cycle after value 6.
- R=1, W=1, K_IN=0xDEAD -> one output with both strobes and K_OUT=0xDEAD, then READY next cycle.
- SIZE_R_IN=0, W=4, START -> no output strobes; READY pulses 2 cycles after START.
- R=2, W=2, gaps of 3 idle cycles between elements, plus START re-pulsed mid-transfer -> outputs identical to the gap-free case; mid-transfer START has no effect; exactly one READY.
- R=3, W=4, RST low after 5th element, then a new START with R=1, W=2 -> outputs cleared asynchronously, no READY from the first transfer; second transfer completes with 2 elements and READY.
- With PROTOCOL_CHECK_EN: K_IN_I_ENABLE=1 on 2nd element of a W=3 row -> ERROR=1, element still output; ERROR stays 1 until the next START, then returns to 0.

Source files
------------

// File: rtl/accelerator_read_keys.sv
// Read-key head: re-emits the RxW read-key element stream, registered, with row/element strobes.
// Optional macro ACCELERATOR_READ_KEYS_PROTOCOL_CHECK_EN adds a sticky ERROR output.
module accelerator_read_keys #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 K_IN_I_ENABLE,
  input  logic                 K_IN_K_ENABLE,
  output logic                 K_OUT_I_ENABLE,
  output logic                 K_OUT_K_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0] K_IN,
`ifdef ACCELERATOR_READ_KEYS_PROTOCOL_CHECK_EN
  output logic                 ERROR,
`endif
  output logic [DATA_SIZE-1:0] K_OUT
);

  // CONTROL_SIZE only exists so all head blocks share one parameter list.
  if (CONTROL_SIZE < 1) begin : g_bad_control_size
    $error("accelerator_read_keys: CONTROL_SIZE must be positive");
  end

  typedef enum logic [1:0] {
    STARTER = 2'd0,
    INPUT_I = 2'd1,
    INPUT_K = 2'd2,
    ENDER   = 2'd3
  } state_t;

  localparam logic [DATA_SIZE-1:0] ONE  = DATA_SIZE'(1);
  localparam logic [DATA_SIZE-1:0] ZERO = '0;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] size_r_q, size_r_d;
  logic [DATA_SIZE-1:0] size_w_q, size_w_d;
  logic [DATA_SIZE-1:0] index_i_q, index_i_d;
  logic [DATA_SIZE-1:0] index_k_q, index_k_d;
  logic                 accept;
  logic                 ready_d;
  logic                 out_i_d;
  logic                 out_k_d;

  always_comb begin
    state_d   = state_q;
    size_r_d  = size_r_q;
    size_w_d  = size_w_q;
    index_i_d = index_i_q;
    index_k_d = index_k_q;
    accept    = 1'b0;
    ready_d   = 1'b0;
    out_i_d   = 1'b0;
    out_k_d   = 1'b0;

    case (state_q)
      STARTER: begin
        if (START) begin
          size_r_d  = SIZE_R_IN;
          size_w_d  = SIZE_W_IN;
          index_i_d = ZERO;
          index_k_d = ZERO;
          state_d   = (SIZE_R_IN == ZERO || SIZE_W_IN == ZERO) ? ENDER : INPUT_I;
        end
      end
      INPUT_I: begin
        if (K_IN_I_ENABLE && K_IN_K_ENABLE) begin
          accept  = 1'b1;
          out_i_d = 1'b1;
        end
      end
      INPUT_K: begin
        if (K_IN_K_ENABLE) begin
          accept = 1'b1;
        end
      end
      ENDER: begin
        ready_d   = 1'b1;
        index_i_d = ZERO;
        index_k_d = ZERO;
        state_d   = STARTER;
      end
      default: state_d = STARTER;
    endcase

    // Both input states share the same row/column walk; W=1 naturally stays in INPUT_I.
    if (accept) begin
      out_k_d = 1'b1;
      if (index_k_q < size_w_q - ONE) begin
        index_k_d = index_k_q + ONE;
        state_d   = INPUT_K;
      end else if (index_i_q < size_r_q - ONE) begin
        index_k_d = ZERO;
        index_i_d = index_i_q + ONE;
        state_d   = INPUT_I;
      end else begin
        state_d = ENDER;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= STARTER;
      size_r_q       <= ZERO;
      size_w_q       <= ZERO;
      index_i_q      <= ZERO;
      index_k_q      <= ZERO;
      READY          <= 1'b0;
      K_OUT_I_ENABLE <= 1'b0;
      K_OUT_K_ENABLE <= 1'b0;
      K_OUT          <= ZERO;
    end else begin
      state_q        <= state_d;
      size_r_q       <= size_r_d;
      size_w_q       <= size_w_d;
      index_i_q      <= index_i_d;
      index_k_q      <= index_k_d;
      READY          <= ready_d;
      K_OUT_I_ENABLE <= out_i_d;
      K_OUT_K_ENABLE <= out_k_d;
      if (accept) begin
        K_OUT <= K_IN;
      end
    end
  end

`ifdef ACCELERATOR_READ_KEYS_PROTOCOL_CHECK_EN
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    case (state_q)
      STARTER: err_set = K_IN_K_ENABLE;
      INPUT_I: err_set = K_IN_K_ENABLE && !K_IN_I_ENABLE;
      INPUT_K: err_set = K_IN_I_ENABLE;
      default: err_set = 1'b0;
    endcase
  end

  // A violation seen in the same cycle as START takes priority over the clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ERROR <= 1'b0;
    end else if (err_set) begin
      ERROR <= 1'b1;
    end else if (state_q == STARTER && START) begin
      ERROR <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_accelerator_read_keys.sv
// Bench for accelerator_read_keys: directed steps plus random traffic against an element-count model.
module tb_accelerator_read_keys;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ien = 1'b0;
  logic        ken = 1'b0;
  logic [63:0] size_r = '0;
  logic [63:0] size_w = '0;
  logic [63:0] kin = '0;
  logic        ready;
  logic        oien;
  logic        oken;
  logic [63:0] kout;

  int checks = 0;
  int errors = 0;

  // Model: a transfer is R*W elements; element n is row-first iff n mod W == 0.
  int              m_phase = 0;  // 0 idle, 1 transferring, 2 completion pending
  longint unsigned m_r = 0, m_w = 0, m_n = 0;
  logic [63:0]     e_kout = '0;
  logic            e_ready = 1'b0, e_ien = 1'b0, e_ken = 1'b0;

  accelerator_read_keys #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .READY(ready),
    .K_IN_I_ENABLE(ien), .K_IN_K_ENABLE(ken),
    .K_OUT_I_ENABLE(oien), .K_OUT_K_ENABLE(oken),
    .SIZE_R_IN(size_r), .SIZE_W_IN(size_w), .K_IN(kin), .K_OUT(kout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, {63'd0, ready}, {63'd0, e_ready});
    chk({tag, ".out_i"}, {63'd0, oien}, {63'd0, e_ien});
    chk({tag, ".out_k"}, {63'd0, oken}, {63'd0, e_ken});
    chk({tag, ".k_out"}, kout, e_kout);
  endtask

  task automatic model_edge();
    bit row_first;
    e_ready = 1'b0;
    e_ien   = 1'b0;
    e_ken   = 1'b0;
    if (m_phase == 2) begin
      e_ready = 1'b1;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_r = size_r;
        m_w = size_w;
        m_n = 0;
        m_phase = (m_r == 0 || m_w == 0) ? 2 : 1;
      end
    end else begin
      row_first = ((m_n % m_w) == 0);
      if (ken && (ien || !row_first)) begin
        e_kout = kin;
        e_ken  = 1'b1;
        e_ien  = row_first;
        m_n++;
        if (m_n == m_r * m_w) m_phase = 2;
      end
    end
  endtask

  task automatic step(input string tag, input logic st, input logic ie, input logic ke,
                      input logic [63:0] kv);
    @(negedge clk);
    start = st;
    ien   = ie;
    ken   = ke;
    kin   = kv;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_phase = 0;
    e_ready = 1'b0;
    e_ien   = 1'b0;
    e_ken   = 1'b0;
    e_kout  = '0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    check_all("reset");
    rst_n = 1'b1;
    idle("post_reset", 2);

    // R=2, W=3 back-to-back
    size_r = 64'd2; size_w = 64'd3;
    step("t1_start", 1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 1; i <= 6; i++)
      step("t1_elem", 1'b0, (i == 1 || i == 4), 1'b1, 64'(i));
    idle("t1_tail", 3);

    // R=1, W=1
    size_r = 64'd1; size_w = 64'd1;
    step("t2_start", 1'b1, 1'b0, 1'b0, 64'd0);
    step("t2_elem", 1'b0, 1'b1, 1'b1, 64'hDEAD);
    idle("t2_tail", 3);

    // R=0 transfers nothing
    size_r = 64'd0; size_w = 64'd4;
    step("t3_start", 1'b1, 1'b0, 1'b0, 64'd0);
    step("t3_elem", 1'b0, 1'b1, 1'b1, 64'h55);
    idle("t3_tail", 3);

    // R=2, W=2 with gaps, START re-pulsed and sizes changed mid-transfer
    size_r = 64'd2; size_w = 64'd2;
    step("t4_start", 1'b1, 1'b0, 1'b0, 64'd0);
    size_r = 64'd7; size_w = 64'd9;
    for (int i = 1; i <= 4; i++) begin
      step("t4_elem", 1'b0, (i == 1 || i == 3), 1'b1, 64'(16 * i));
      step("t4_gap", (i == 2), 1'b0, 1'b0, 64'd0);
      idle("t4_gap", 2);
    end
    // K without I while a row-first element is awaited must be refused
    size_r = 64'd1; size_w = 64'd2;
    step("t4b_start", 1'b1, 1'b0, 1'b0, 64'd0);
    step("t4b_noi", 1'b0, 1'b0, 1'b1, 64'h99);
    step("t4b_e1", 1'b0, 1'b1, 1'b1, 64'hA1);
    step("t4b_e2", 1'b0, 1'b1, 1'b1, 64'hA2);
    idle("t4b_tail", 3);

    // R=3, W=4 aborted by reset after 5 elements, then R=1, W=2
    size_r = 64'd3; size_w = 64'd4;
    step("t5_start", 1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 1; i <= 5; i++)
      step("t5_elem", 1'b0, (i == 1 || i == 5), 1'b1, 64'(100 + i));
    async_reset("t5_reset");
    idle("t5_idle", 3);
    size_r = 64'd1; size_w = 64'd2;
    step("t5b_start", 1'b1, 1'b0, 1'b0, 64'd0);
    step("t5b_e1", 1'b0, 1'b1, 1'b1, 64'hB1);
    step("t5b_e2", 1'b0, 1'b0, 1'b1, 64'hB2);
    idle("t5b_tail", 3);

    // START held high: back-to-back transfers
    size_r = 64'd1; size_w = 64'd1;
    for (int i = 0; i < 6; i++) step("t6_held", 1'b1, 1'b1, 1'b1, 64'(200 + i));
    idle("t6_tail", 2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      size_r = 64'($urandom_range(0, 3));
      size_w = 64'($urandom_range(0, 4));
      step("rand", ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           {32'($urandom), 32'($urandom)});
    end
    idle("rand_tail", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
